// File: rtl/dr_sync_mem_bridge.sv
// dr_sync_mem_bridge: memory-side stage of the dual-rail data port.
// Each 4-phase Access token (plus a Do token for writes) becomes one
// synchronous SRAM cycle. Read data and abort status are returned on the
// Di and Abort pull channels.
module dr_sync_mem_bridge #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       acc_0r0d,
  input  logic [37:0]       acc_0r1d,
  output logic              acc_0a,
  input  logic [31:0]       do_0r0d,
  input  logic [31:0]       do_0r1d,
  output logic              do_0a,
  input  logic              di_0r,
  output logic [31:0]       di_0a0d,
  output logic [31:0]       di_0a1d,
  input  logic              ab_0r,
  output logic              ab_0a0d,
  output logic              ab_0a1d,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_ben,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              proto_err
);

  localparam int unsigned ACC_W  = 38;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BEN_W  = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LATCH  = 3'd1;
  localparam logic [2:0] S_WWAIT  = 3'd2;
  localparam logic [2:0] S_WR     = 3'd3;
  localparam logic [2:0] S_RD     = 3'd4;
  localparam logic [2:0] S_CAP    = 3'd5;
  localparam logic [2:0] S_RESULT = 3'd6;
  localparam logic [2:0] S_RTZ    = 3'd7;

  // Synchroniser chains: index 0 takes the raw input, the last index is used.
  logic [SYNC_STAGES-1:0][ACC_W-1:0]  acc0_sync_q, acc1_sync_q;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] do0_sync_q, do1_sync_q;
  logic [SYNC_STAGES-1:0]             di_req_sync_q, ab_req_sync_q;

  logic [ACC_W-1:0]  acc0_s, acc1_s;
  logic [DATA_W-1:0] do0_s, do1_s;
  logic              di_req_s, ab_req_s;

  logic acc_complete_c, acc_spacer_c, do_complete_c, do_spacer_c;
  logic err_c, freeze_c;

  logic [31:0]       dec_addr_c;
  logic [1:0]        dec_size_c;
  logic              dec_write_c;
  logic              dec_abort_c;
  logic [ADDR_W-1:0] dec_waddr_c;
  logic [BEN_W-1:0]  dec_ben_c;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [BEN_W-1:0]  ben_q, ben_d;
  logic              write_q, write_d;
  logic              abort_q, abort_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_pend_q, rd_pend_d;
  logic              ab_pend_q, ab_pend_d;
  logic              acc_ack_q, acc_ack_d;
  logic              do_ack_q, do_ack_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [BEN_W-1:0]  mem_ben_q, mem_ben_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              proto_err_q, proto_err_d;
  logic [DATA_W-1:0] di_r0_q, di_r0_d, di_r1_q, di_r1_d;
  logic              di_tok_q, di_tok_d;
  logic              ab_r0_q, ab_r0_d, ab_r1_q, ab_r1_d;
  logic              ab_tok_q, ab_tok_d;

  // Shift every rail bit and pull request through its synchroniser.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc0_sync_q   <= '0;
      acc1_sync_q   <= '0;
      do0_sync_q    <= '0;
      do1_sync_q    <= '0;
      di_req_sync_q <= '0;
      ab_req_sync_q <= '0;
    end else begin
      acc0_sync_q   <= {acc0_sync_q[SYNC_STAGES-2:0], acc_0r0d};
      acc1_sync_q   <= {acc1_sync_q[SYNC_STAGES-2:0], acc_0r1d};
      do0_sync_q    <= {do0_sync_q[SYNC_STAGES-2:0], do_0r0d};
      do1_sync_q    <= {do1_sync_q[SYNC_STAGES-2:0], do_0r1d};
      di_req_sync_q <= {di_req_sync_q[SYNC_STAGES-2:0], di_0r};
      ab_req_sync_q <= {ab_req_sync_q[SYNC_STAGES-2:0], ab_0r};
    end
  end

  assign acc0_s   = acc0_sync_q[SYNC_STAGES-1];
  assign acc1_s   = acc1_sync_q[SYNC_STAGES-1];
  assign do0_s    = do0_sync_q[SYNC_STAGES-1];
  assign do1_s    = do1_sync_q[SYNC_STAGES-1];
  assign di_req_s = di_req_sync_q[SYNC_STAGES-1];
  assign ab_req_s = ab_req_sync_q[SYNC_STAGES-1];

  // Completion, spacer and both-rails-high detection on synchronised rails.
  always_comb begin
    acc_complete_c = &(acc0_s ^ acc1_s);
    acc_spacer_c   = ~|(acc0_s | acc1_s);
    do_complete_c  = &(do0_s ^ do1_s);
    do_spacer_c    = ~|(do0_s | do1_s);
    err_c          = (|(acc0_s & acc1_s)) | (|(do0_s & do1_s));
    freeze_c       = proto_err_q | err_c;
  end

  // Access decode from the rail-1 values; misaligned addresses align down.
  always_comb begin
    dec_addr_c  = acc1_s[31:0];
    dec_size_c  = acc1_s[33:32];
    dec_write_c = acc1_s[34];
    dec_abort_c = (|(dec_addr_c >> (ADDR_W + 2))) | (dec_size_c == 2'b11);
    dec_waddr_c = dec_addr_c[ADDR_W+1:2];
    case (dec_size_c)
      2'b00:   dec_ben_c = BEN_W'(4'b0001 << dec_addr_c[1:0]);
      2'b01:   dec_ben_c = dec_addr_c[1] ? 4'b1100 : 4'b0011;
      default: dec_ben_c = 4'b1111;
    endcase
  end

  // Next-state logic: pull channels, then the access FSM.
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    ben_d       = ben_q;
    write_d     = write_q;
    abort_d     = abort_q;
    rdata_d     = rdata_q;
    rd_pend_d   = rd_pend_q;
    ab_pend_d   = ab_pend_q;
    acc_ack_d   = acc_ack_q;
    do_ack_d    = do_ack_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_ben_d   = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    proto_err_d = proto_err_q | err_c;

    // Di: present the read token while requested; retire it when the request drops.
    di_tok_d = di_req_s & rd_pend_q;
    di_r1_d  = di_tok_d ? rdata_q : '0;
    di_r0_d  = di_tok_d ? ~rdata_q : '0;
    if (di_tok_q && !di_req_s) rd_pend_d = 1'b0;

    // Abort: same handshake, one bit carrying the latched abort status.
    ab_tok_d = ab_req_s & ab_pend_q;
    ab_r1_d  = ab_tok_d & abort_q;
    ab_r0_d  = ab_tok_d & ~abort_q;
    if (ab_tok_q && !ab_req_s) ab_pend_d = 1'b0;

    if (!freeze_c) begin
      case (state_q)
        S_IDLE: begin
          if (acc_complete_c && !rd_pend_q && !ab_pend_q) state_d = S_LATCH;
        end
        S_LATCH: begin
          waddr_d = dec_waddr_c;
          ben_d   = dec_ben_c;
          write_d = dec_write_c;
          abort_d = dec_abort_c;
          if (dec_write_c) begin
            state_d = S_WWAIT;
          end else if (dec_abort_c) begin
            state_d = S_RESULT;
          end else begin
            state_d    = S_RD;
            mem_en_d   = 1'b1;
            mem_addr_d = dec_waddr_c;
            mem_ben_d  = dec_ben_c;
          end
        end
        S_WWAIT: begin
          // Do is consumed even for an aborted write, but no SRAM cycle follows.
          if (do_complete_c) begin
            if (abort_q) begin
              state_d = S_RESULT;
            end else begin
              state_d     = S_WR;
              mem_en_d    = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = waddr_q;
              mem_ben_d   = ben_q;
              mem_wdata_d = do1_s;
            end
          end
        end
        S_WR:  state_d = S_RESULT;
        S_RD:  state_d = S_CAP;
        S_CAP: begin
          rdata_d   = mem_rdata;
          rd_pend_d = 1'b1;
          state_d   = S_RESULT;
        end
        S_RESULT: begin
          ab_pend_d = 1'b1;
          acc_ack_d = 1'b1;
          do_ack_d  = write_q;
          state_d   = S_RTZ;
        end
        S_RTZ: begin
          if (acc_spacer_c && (!write_q || do_spacer_c)) begin
            acc_ack_d = 1'b0;
            do_ack_d  = 1'b0;
            state_d   = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      waddr_q     <= '0;
      ben_q       <= '0;
      write_q     <= 1'b0;
      abort_q     <= 1'b0;
      rdata_q     <= '0;
      rd_pend_q   <= 1'b0;
      ab_pend_q   <= 1'b0;
      acc_ack_q   <= 1'b0;
      do_ack_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_ben_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      proto_err_q <= 1'b0;
      di_r0_q     <= '0;
      di_r1_q     <= '0;
      di_tok_q    <= 1'b0;
      ab_r0_q     <= 1'b0;
      ab_r1_q     <= 1'b0;
      ab_tok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      ben_q       <= ben_d;
      write_q     <= write_d;
      abort_q     <= abort_d;
      rdata_q     <= rdata_d;
      rd_pend_q   <= rd_pend_d;
      ab_pend_q   <= ab_pend_d;
      acc_ack_q   <= acc_ack_d;
      do_ack_q    <= do_ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_ben_q   <= mem_ben_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      proto_err_q <= proto_err_d;
      di_r0_q     <= di_r0_d;
      di_r1_q     <= di_r1_d;
      di_tok_q    <= di_tok_d;
      ab_r0_q     <= ab_r0_d;
      ab_r1_q     <= ab_r1_d;
      ab_tok_q    <= ab_tok_d;
    end
  end

  assign acc_0a    = acc_ack_q;
  assign do_0a     = do_ack_q;
  assign di_0a0d   = di_r0_q;
  assign di_0a1d   = di_r1_q;
  assign ab_0a0d   = ab_r0_q;
  assign ab_0a1d   = ab_r1_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_ben   = mem_ben_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_dr_sync_mem_bridge.sv
// Bench for dr_sync_mem_bridge: SRAM model, processor-side handshakes and a
// word-level reference memory that predicts abort status and read data.
module tb_dr_sync_mem_bridge;

  localparam int unsigned ADDR_W    = 14;
  localparam int unsigned SYNC      = 2;
  localparam int unsigned MEM_WORDS = 1 << ADDR_W;
  localparam int unsigned TMO       = 200;

  logic              clk;
  logic              reset;
  logic [37:0]       acc_0r0d, acc_0r1d;
  logic              acc_0a;
  logic [31:0]       do_0r0d, do_0r1d;
  logic              do_0a;
  logic              di_0r;
  logic [31:0]       di_0a0d, di_0a1d;
  logic              ab_0r;
  logic              ab_0a0d, ab_0a1d;
  logic              mem_en, mem_we;
  logic [3:0]        mem_ben;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              proto_err;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  dr_sync_mem_bridge #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset),
    .acc_0r0d(acc_0r0d), .acc_0r1d(acc_0r1d), .acc_0a(acc_0a),
    .do_0r0d(do_0r0d), .do_0r1d(do_0r1d), .do_0a(do_0a),
    .di_0r(di_0r), .di_0a0d(di_0a0d), .di_0a1d(di_0a1d),
    .ab_0r(ab_0r), .ab_0a0d(ab_0a0d), .ab_0a1d(ab_0a1d),
    .mem_en(mem_en), .mem_we(mem_we), .mem_ben(mem_ben),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .proto_err(proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Power-on SRAM contents, shared by the SRAM model and the reference.
  function automatic logic [31:0] init_word(input int unsigned a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return 32'(a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // SRAM model plus activity monitor.
  logic [31:0]  sram [int unsigned];
  int unsigned  en_cnt = 0;
  logic         prev_en = 1'b0;
  logic         double_en = 1'b0;
  logic         last_we;
  logic [3:0]   last_ben;
  logic [ADDR_W-1:0] last_addr;
  logic [31:0]  last_wdata;

  always @(posedge clk) begin
    logic [31:0] cur;
    if (mem_en) begin
      cur = sram.exists(32'(mem_addr)) ? sram[32'(mem_addr)] : init_word(32'(mem_addr));
      if (mem_we) begin
        for (int k = 0; k < 4; k++) if (mem_ben[k]) cur[8*k +: 8] = mem_wdata[8*k +: 8];
        sram[32'(mem_addr)] = cur;
      end else begin
        mem_rdata <= cur;
      end
      en_cnt++;
      last_we    = mem_we;
      last_ben   = mem_ben;
      last_addr  = mem_addr;
      last_wdata = mem_wdata;
    end
    if (mem_en && prev_en) double_en = 1'b1;
    prev_en = mem_en;
  end

  // Reference memory: what the processor expects after its own writes.
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] ref_rd(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] sram_rd(input int unsigned w);
    return sram.exists(w) ? sram[w] : init_word(w);
  endfunction

  function automatic logic m_abort(input logic [31:0] a, input logic [1:0] s);
    return (64'(a) >= 64'(4 * MEM_WORDS)) || (s == 2'd3);
  endfunction

  function automatic int unsigned m_word(input logic [31:0] a);
    return (a / 4) % MEM_WORDS;
  endfunction

  function automatic logic [3:0] m_ben(input logic [31:0] a, input logic [1:0] s);
    case (s)
      2'd0:    return 4'(1 << (a % 4));
      2'd1:    return ((a % 4) >= 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_acc(input logic [31:0] a, input logic [1:0] s, input logic wr,
                           input logic [31:0] wd);
    logic [37:0] tok;
    tok = {3'b000, wr, s, a};
    acc_0r1d = tok;
    acc_0r0d = ~tok;
    if (wr) begin
      do_0r1d = wd;
      do_0r0d = ~wd;
    end
  endtask

  task automatic drive_spacer();
    acc_0r0d = '0;
    acc_0r1d = '0;
    do_0r0d  = '0;
    do_0r1d  = '0;
  endtask

  task automatic wait_acc(input logic lvl, input string tag);
    int unsigned n = 0;
    while (acc_0a !== lvl && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(acc_0a), 64'(lvl));
  endtask

  task automatic pull_ab(output logic v);
    int unsigned n = 0;
    ab_0r = 1'b1;
    while ((ab_0a0d | ab_0a1d) == 1'b0 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("ab_token_complete", 64'(ab_0a0d ^ ab_0a1d), 64'd1);
    v = ab_0a1d;
    ab_0r = 1'b0;
    n = 0;
    while ((ab_0a0d | ab_0a1d) != 1'b0 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("ab_spacer", 64'({ab_0a0d, ab_0a1d}), 64'd0);
  endtask

  task automatic pull_di(output logic [31:0] v);
    int unsigned n = 0;
    di_0r = 1'b1;
    while ((di_0a0d ^ di_0a1d) != 32'hFFFF_FFFF && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("di_token_complete", 64'(di_0a0d ^ di_0a1d), 64'hFFFF_FFFF);
    v = di_0a1d;
    di_0r = 1'b0;
    n = 0;
    while ((di_0a0d | di_0a1d) != '0 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("di_spacer", {di_0a0d, di_0a1d}, 64'd0);
  endtask

  task automatic probe_no_di(input string tag);
    di_0r = 1'b1;
    repeat (16) @(negedge clk);
    check(tag, {di_0a0d, di_0a1d}, 64'd0);
    di_0r = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // One full processor-side access, checked against the reference model.
  task automatic do_txn(input logic [31:0] a, input logic [1:0] s, input logic wr,
                        input logic [31:0] wd, input string tag);
    logic        exp_ab, ab_v;
    logic [31:0] d, merged;
    logic [3:0]  eb;
    int unsigned wi, base;
    exp_ab = m_abort(a, s);
    wi     = m_word(a);
    eb     = m_ben(a, s);
    base   = en_cnt;
    @(negedge clk);
    drive_acc(a, s, wr, wd);
    wait_acc(1'b1, {tag, ":acc_ack_rise"});
    check({tag, ":do_ack_rise"}, 64'(do_0a), 64'(wr));
    drive_spacer();
    wait_acc(1'b0, {tag, ":acc_ack_fall"});
    check({tag, ":do_ack_fall"}, 64'(do_0a), 64'd0);
    check({tag, ":mem_en_pulses"}, 64'(en_cnt - base), exp_ab ? 64'd0 : 64'd1);
    if (!exp_ab) begin
      check({tag, ":mem_we"}, 64'(last_we), 64'(wr));
      check({tag, ":mem_addr"}, 64'(last_addr), 64'(wi));
      if (wr) begin
        check({tag, ":mem_ben"}, 64'(last_ben), 64'(eb));
        check({tag, ":mem_wdata"}, 64'(last_wdata), 64'(wd));
      end
    end
    pull_ab(ab_v);
    check({tag, ":abort_value"}, 64'(ab_v), 64'(exp_ab));
    if (!wr) begin
      if (!exp_ab) begin
        pull_di(d);
        check({tag, ":read_data"}, 64'(d), 64'(ref_rd(wi)));
      end else begin
        probe_no_di({tag, ":no_di_on_abort"});
      end
    end else if (!exp_ab) begin
      merged = ref_rd(wi);
      for (int k = 0; k < 4; k++) if (eb[k]) merged[8*k +: 8] = wd[8*k +: 8];
      ref_mem[wi] = merged;
      check({tag, ":sram_contents"}, 64'(sram_rd(wi)), 64'(merged));
    end
  endtask

  initial begin
    logic        v;
    logic [31:0] d, a, wd;
    logic [1:0]  sz;
    logic        wr;
    int unsigned base, n;

    reset = 1'b0;
    di_0r = 1'b0;
    ab_0r = 1'b0;
    drive_spacer();
    repeat (4) @(negedge clk);
    check("reset_outputs", {acc_0a, do_0a, mem_en, mem_we, mem_ben, proto_err, ab_0a0d, ab_0a1d},
          64'd0);
    check("reset_di_rails", {di_0a0d, di_0a1d}, 64'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_after_reset", {acc_0a, mem_en, mem_addr, mem_wdata}, 64'd0);

    // Directed accesses.
    do_txn(32'h0000_0040, 2'b10, 1'b0, 32'h0, "rd_word");
    do_txn(32'h0000_0103, 2'b00, 1'b1, 32'h0000_00AA, "wr_byte");
    do_txn(32'h0000_0100, 2'b10, 1'b0, 32'h0, "rd_after_byte_wr");
    do_txn(32'h0000_0022, 2'b01, 1'b1, 32'h1234_5678, "wr_half_hi");
    do_txn(32'h0000_0020, 2'b10, 1'b0, 32'h0, "rd_after_half_wr");
    do_txn(32'h0000_0047, 2'b10, 1'b0, 32'h0, "rd_misaligned");
    do_txn(32'h0000_FFFC, 2'b10, 1'b0, 32'h0, "rd_top_word");
    do_txn(32'h0001_0000, 2'b10, 1'b0, 32'h0, "oor_read");
    do_txn(32'h0000_0044, 2'b11, 1'b0, 32'h0, "illegal_size");
    do_txn(32'h8000_0000, 2'b10, 1'b1, 32'hCAFE_F00D, "oor_write");

    // Second access issued before the first one's tokens are pulled.
    @(negedge clk);
    drive_acc(32'h40, 2'b10, 1'b0, 32'h0);
    wait_acc(1'b1, "b2b_first_ack_rise");
    drive_spacer();
    wait_acc(1'b0, "b2b_first_ack_fall");
    base = en_cnt;
    @(negedge clk);
    drive_acc(32'h44, 2'b10, 1'b0, 32'h0);
    repeat (30) @(negedge clk);
    check("b2b_blocked_ack", 64'(acc_0a), 64'd0);
    check("b2b_blocked_mem", 64'(en_cnt - base), 64'd0);
    pull_ab(v);
    check("b2b_first_abort", 64'(v), 64'd0);
    repeat (10) @(negedge clk);
    check("b2b_still_blocked_on_di", 64'(acc_0a), 64'd0);
    pull_di(d);
    check("b2b_first_data", 64'(d), 64'(ref_rd(32'h10)));
    wait_acc(1'b1, "b2b_second_ack_rise");
    drive_spacer();
    wait_acc(1'b0, "b2b_second_ack_fall");
    check("b2b_second_mem_en", 64'(en_cnt - base), 64'd1);
    pull_ab(v);
    check("b2b_second_abort", 64'(v), 64'd0);
    pull_di(d);
    check("b2b_second_data", 64'(d), 64'(ref_rd(32'h11)));

    // Randomised accesses, concentrated on a small region so reads hit writes.
    for (int i = 0; i < 48; i++) begin
      n = $urandom_range(0, 9);
      if (n == 0) a = $urandom | 32'h0001_0000;
      else        a = $urandom_range(0, 511);
      sz = 2'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      do_txn(a, sz, wr, wd, "rand");
    end
    check("no_back_to_back_mem_en", 64'(double_en), 64'd0);

    // Both rails high on bit 5: sticky error, no SRAM activity, no ack.
    base = en_cnt;
    @(negedge clk);
    drive_acc(32'h40, 2'b10, 1'b0, 32'h0);
    acc_0r0d[5] = 1'b1;
    acc_0r1d[5] = 1'b1;
    repeat (12) @(negedge clk);
    check("perr_flag", 64'(proto_err), 64'd1);
    check("perr_no_mem", 64'(en_cnt - base), 64'd0);
    check("perr_no_ack", 64'({acc_0a, do_0a}), 64'd0);
    drive_spacer();
    repeat (8) @(negedge clk);
    check("perr_sticky", 64'(proto_err), 64'd1);
    check("perr_frozen_ack", 64'(acc_0a), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("perr_cleared_by_reset", 64'(proto_err), 64'd0);

    // Reset asserted while the read's SRAM cycle is in flight.
    @(negedge clk);
    drive_acc(32'h40, 2'b10, 1'b0, 32'h0);
    n = 0;
    while (mem_en !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_rd_reached", 64'(mem_en), 64'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_ctrl", {acc_0a, do_0a, mem_en, mem_we, mem_ben, proto_err, ab_0a0d, ab_0a1d},
          64'd0);
    check("rst_mid_addr_data", {mem_addr, mem_wdata}, 64'd0);
    check("rst_mid_di", {di_0a0d, di_0a1d}, 64'd0);
    drive_spacer();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    do_txn(32'h0000_0040, 2'b10, 1'b0, 32'h0, "rd_after_reset");
    check("final_no_back_to_back_mem_en", 64'(double_en), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
